pe_ws: RTL and testbench

Weight-stationary systolic processing element with an N-bank weight store, tagged weight delivery and valid-qualified multiply-accumulate. It generalises the double-buffered PE to a parametrised bank count and signed/unsigned operands. It adds explicit activation/psum valid tracking, hop-addressed weight loading down a column, and an unloaded-bank error flag. Instances tile into the systolic array: activations flow east, weights and partial sums flow south.

---
 rtl/pe_pkg.sv | 46 ++++
 rtl/pe_weight_bank.sv | 42 ++++
 rtl/pe_ws.sv | 156 +++++++++++++++
 tb/tb_pe_ws.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared defaults, weight-beat record and saturating add for the weight-stationary PE.
// Pure declarations; no state, no latency.
package pe_pkg;

    localparam int PE_DATA_WIDTH = 8;
    localparam int PE_ACC_WIDTH  = 32;
    localparam int PE_WBANKS     = 2;
    localparam int PE_ROWS       = 8;

    // Weight beat at the default geometry (2 banks, 8 rows).
    typedef struct packed {
        logic                                valid;
        logic [PE_DATA_WIDTH-1:0]            data;
        logic [$clog2(PE_WBANKS)-1:0]        bank;
        logic [$clog2(PE_ROWS)-1:0]          hop;
    } w_beat_t;

    // Operands arrive already extended to 64 bits; the clamp is applied at acc_w bits (acc_w <= 64).
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned acc_w,
                                            input logic        is_signed);
        logic [64:0] sum;
        logic [64:0] max_v;
        logic [64:0] min_v;
        logic [63:0] res;
        sum   = {is_signed & a[63], a} + {is_signed & b[63], b};
        res   = sum[63:0];
        if (is_signed) begin
            max_v = (65'd1 << (acc_w - 1)) - 65'd1;
            min_v = ~max_v;
            if ($signed(sum) > $signed(max_v)) begin
                res = max_v[63:0];
            end else if ($signed(sum) < $signed(min_v)) begin
                res = min_v[63:0];
            end
        end else begin
            max_v = (65'd1 << acc_w) - 65'd1;
            if (sum > max_v) begin
                res = max_v[63:0];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pe_weight_bank.sv
// WBANKS weight registers with loaded flags; one write port, one combinational read port.
// Read returns pre-write contents in the cycle of a write; out-of-range reads give 0 and not-loaded.
module pe_weight_bank #(
    parameter  int DATA_WIDTH = 8,
    parameter  int WBANKS     = 2,
    localparam int BANK_W     = $clog2(WBANKS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [BANK_W-1:0]     wr_bank_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [BANK_W-1:0]     rd_bank_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_loaded_o
);

    logic [DATA_WIDTH-1:0] r_bank [WBANKS];
    logic [WBANKS-1:0]     r_loaded;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < WBANKS; i++) begin
                r_bank[i] <= '0;
            end
            r_loaded <= '0;
        end else if (wr_en_i && (int'(wr_bank_i) < WBANKS)) begin
            r_bank[wr_bank_i]   <= wr_data_i;
            r_loaded[wr_bank_i] <= 1'b1;
        end
    end

    always_comb begin
        rd_data_o   = '0;
        rd_loaded_o = 1'b0;
        if (int'(rd_bank_i) < WBANKS) begin
            rd_data_o   = r_bank[rd_bank_i];
            rd_loaded_o = r_loaded[rd_bank_i];
        end
    end

endmodule

// File: rtl/pe_ws.sv
// Weight-stationary systolic PE: hop-addressed weight load, banked weights, valid-qualified MAC.
// All outputs registered, 1-cycle latency, no backpressure. PE_SAT_EN selects saturating accumulation.
module pe_ws
    import pe_pkg::*;
#(
    parameter  int DATA_WIDTH = PE_DATA_WIDTH,
    parameter  int ACC_WIDTH  = PE_ACC_WIDTH,
    parameter  int WBANKS     = PE_WBANKS,
    parameter  int ROWS       = PE_ROWS,
    parameter  int SIGNED     = 1,
    localparam int BANK_W     = $clog2(WBANKS),
    localparam int HOP_W      = $clog2(ROWS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  act_valid_i,
    input  logic [DATA_WIDTH-1:0] act_i,
    input  logic [BANK_W-1:0]     act_bank_i,
    output logic                  act_valid_o,
    output logic [DATA_WIDTH-1:0] act_o,
    output logic [BANK_W-1:0]     act_bank_o,
    input  logic                  w_valid_i,
    input  logic [DATA_WIDTH-1:0] w_data_i,
    input  logic [BANK_W-1:0]     w_bank_i,
    input  logic [HOP_W-1:0]      w_hop_i,
    output logic                  w_valid_o,
    output logic [DATA_WIDTH-1:0] w_data_o,
    output logic [BANK_W-1:0]     w_bank_o,
    output logic [HOP_W-1:0]      w_hop_o,
    input  logic [ACC_WIDTH-1:0]  psum_i,
    output logic [ACC_WIDTH-1:0]  psum_o,
    output logic                  psum_valid_o,
    output logic                  err_o
);

    localparam int PROD_W = 2 * DATA_WIDTH;

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
        logic [BANK_W-1:0]     bank;
        logic [HOP_W-1:0]      hop;
    } beat_t;

    beat_t                 r_w;
    logic                  r_act_vld;
    logic [DATA_WIDTH-1:0] r_act;
    logic [BANK_W-1:0]     r_act_bank;
    logic [ACC_WIDTH-1:0]  r_psum;
    logic                  r_psum_vld;
    logic                  r_err;

    logic                  w_capture;
    logic [DATA_WIDTH-1:0] w_weight;
    logic                  w_loaded;
    logic [PROD_W-1:0]     w_a_x;
    logic [PROD_W-1:0]     w_b_x;
    logic [PROD_W-1:0]     w_prod;
    logic [ACC_WIDTH-1:0]  w_prod_ext;
    logic [ACC_WIDTH-1:0]  w_mac;

    assign w_capture = w_valid_i && (w_hop_i == '0);

    pe_weight_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .WBANKS     (WBANKS)
    ) u_bank (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (w_capture),
        .wr_bank_i   (w_bank_i),
        .wr_data_i   (w_data_i),
        .rd_bank_i   (act_bank_i),
        .rd_data_o   (w_weight),
        .rd_loaded_o (w_loaded)
    );

    // Operands are widened before the multiply so the low PROD_W bits are exact in either mode.
    if (SIGNED != 0) begin : g_signed
        assign w_a_x      = PROD_W'($signed(act_i));
        assign w_b_x      = PROD_W'($signed(w_weight));
        assign w_prod_ext = ACC_WIDTH'($signed(w_prod));
    end else begin : g_unsigned
        assign w_a_x      = PROD_W'(act_i);
        assign w_b_x      = PROD_W'(w_weight);
        assign w_prod_ext = ACC_WIDTH'(w_prod);
    end

    assign w_prod = w_a_x * w_b_x;

`ifdef PE_SAT_EN
    logic [63:0] w_psum_x;
    logic [63:0] w_prod_x;
    logic [63:0] w_sat;
    if (SIGNED != 0) begin : g_sat_sx
        assign w_psum_x = 64'($signed(psum_i));
        assign w_prod_x = 64'($signed(w_prod_ext));
    end else begin : g_sat_zx
        assign w_psum_x = 64'(psum_i);
        assign w_prod_x = 64'(w_prod_ext);
    end
    assign w_sat = sat_add(w_psum_x, w_prod_x, ACC_WIDTH, 1'(SIGNED != 0));
    assign w_mac = w_sat[ACC_WIDTH-1:0];
`else
    assign w_mac = psum_i + w_prod_ext;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_w        <= '0;
            r_act_vld  <= 1'b0;
            r_act      <= '0;
            r_act_bank <= '0;
            r_psum     <= '0;
            r_psum_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_act_vld  <= act_valid_i;
            r_act      <= act_i;
            r_act_bank <= act_bank_i;

            // Captured or idle beats clear valid but leave the last forwarded payload in place.
            if (w_valid_i && (w_hop_i != '0)) begin
                r_w.valid <= 1'b1;
                r_w.data  <= w_data_i;
                r_w.bank  <= w_bank_i;
                r_w.hop   <= w_hop_i - HOP_W'(1);
            end else begin
                r_w.valid <= 1'b0;
            end

            if (act_valid_i) begin
                r_psum     <= w_mac;
                r_psum_vld <= 1'b1;
                if (!w_loaded) begin
                    r_err <= 1'b1;
                end
            end else begin
                r_psum     <= psum_i;
                r_psum_vld <= 1'b0;
            end
        end
    end

    assign act_valid_o  = r_act_vld;
    assign act_o        = r_act;
    assign act_bank_o   = r_act_bank;
    assign w_valid_o    = r_w.valid;
    assign w_data_o     = r_w.data;
    assign w_bank_o     = r_w.bank;
    assign w_hop_o      = r_w.hop;
    assign psum_o       = r_psum;
    assign psum_valid_o = r_psum_vld;
    assign err_o        = r_err;

endmodule

// File: tb/tb_pe_ws.sv
// Bench for pe_ws: directed vector table, hand-written multi-cycle sequences, then random traffic
// compared against an arithmetic reference model (PE_SAT_EN aware).
module tb_pe_ws;

    localparam int DW = 8;
    localparam int AW = 32;
    localparam int NB = 2;
    localparam int NR = 8;
    localparam int BW = 1;
    localparam int HW = 3;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          act_valid_i;
    logic [DW-1:0] act_i;
    logic [BW-1:0] act_bank_i;
    logic          act_valid_o;
    logic [DW-1:0] act_o;
    logic [BW-1:0] act_bank_o;
    logic          w_valid_i;
    logic [DW-1:0] w_data_i;
    logic [BW-1:0] w_bank_i;
    logic [HW-1:0] w_hop_i;
    logic          w_valid_o;
    logic [DW-1:0] w_data_o;
    logic [BW-1:0] w_bank_o;
    logic [HW-1:0] w_hop_o;
    logic [AW-1:0] psum_i;
    logic [AW-1:0] psum_o;
    logic          psum_valid_o;
    logic          err_o;

    pe_ws #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .WBANKS     (NB),
        .ROWS       (NR),
        .SIGNED     (1)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .act_valid_i  (act_valid_i),
        .act_i        (act_i),
        .act_bank_i   (act_bank_i),
        .act_valid_o  (act_valid_o),
        .act_o        (act_o),
        .act_bank_o   (act_bank_o),
        .w_valid_i    (w_valid_i),
        .w_data_i     (w_data_i),
        .w_bank_i     (w_bank_i),
        .w_hop_i      (w_hop_i),
        .w_valid_o    (w_valid_o),
        .w_data_o     (w_data_o),
        .w_bank_o     (w_bank_o),
        .w_hop_o      (w_hop_o),
        .psum_i       (psum_i),
        .psum_o       (psum_o),
        .psum_valid_o (psum_valid_o),
        .err_o        (err_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference state: what each register should hold after the edge.
    logic [DW-1:0] m_bank [NB];
    logic          m_loaded [NB];
    logic          m_err;
    logic          m_act_vld;
    logic [DW-1:0] m_act;
    logic [BW-1:0] m_act_bank;
    logic          m_w_vld;
    logic [DW-1:0] m_w_data;
    logic [BW-1:0] m_w_bank;
    logic [HW-1:0] m_w_hop;
    logic [AW-1:0] m_psum;
    logic          m_psum_vld;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic model_step(input logic rst, input logic wv, input logic [DW-1:0] wd,
                              input logic [BW-1:0] wb, input logic [HW-1:0] wh,
                              input logic av, input logic [DW-1:0] a, input logic [BW-1:0] ab,
                              input logic [AW-1:0] ps);
        longint sum;
        if (rst) begin
            for (int i = 0; i < NB; i++) begin
                m_bank[i]   = '0;
                m_loaded[i] = 1'b0;
            end
            m_err = 0; m_act_vld = 0; m_act = '0; m_act_bank = '0;
            m_w_vld = 0; m_w_data = '0; m_w_bank = '0; m_w_hop = '0;
            m_psum = '0; m_psum_vld = 0;
            return;
        end
        m_act_vld  = av;
        m_act      = a;
        m_act_bank = ab;
        if (av) begin
            sum = longint'($signed(ps)) + longint'($signed(a)) * longint'($signed(m_bank[ab]));
`ifdef PE_SAT_EN
            if (sum > SMAX) sum = SMAX;
            else if (sum < SMIN) sum = SMIN;
`endif
            m_psum     = 32'(sum);
            m_psum_vld = 1'b1;
            if (!m_loaded[ab]) m_err = 1'b1;
        end else begin
            m_psum     = ps;
            m_psum_vld = 1'b0;
        end
        if (wv && wh == 0) begin
            m_bank[wb]   = wd;
            m_loaded[wb] = 1'b1;
            m_w_vld      = 1'b0;
        end else if (wv) begin
            m_w_vld  = 1'b1;
            m_w_data = wd;
            m_w_bank = wb;
            m_w_hop  = wh - 3'd1;
        end else begin
            m_w_vld = 1'b0;
        end
    endtask

    task automatic step(input logic rst, input logic wv, input logic [DW-1:0] wd,
                        input logic [BW-1:0] wb, input logic [HW-1:0] wh,
                        input logic av, input logic [DW-1:0] a, input logic [BW-1:0] ab,
                        input logic [AW-1:0] ps);
        rst_i = rst; w_valid_i = wv; w_data_i = wd; w_bank_i = wb; w_hop_i = wh;
        act_valid_i = av; act_i = a; act_bank_i = ab; psum_i = ps;
        model_step(rst, wv, wd, wb, wh, av, a, ab, ps);
        @(posedge clk);
        #1;
        check("act_valid_o",  64'(act_valid_o),  64'(m_act_vld));
        check("act_o",        64'(act_o),        64'(m_act));
        check("act_bank_o",   64'(act_bank_o),   64'(m_act_bank));
        check("w_valid_o",    64'(w_valid_o),    64'(m_w_vld));
        check("w_data_o",     64'(w_data_o),     64'(m_w_data));
        check("w_bank_o",     64'(w_bank_o),     64'(m_w_bank));
        check("w_hop_o",      64'(w_hop_o),      64'(m_w_hop));
        check("psum_o",       64'(psum_o),       64'(m_psum));
        check("psum_valid_o", 64'(psum_valid_o), 64'(m_psum_vld));
        check("err_o",        64'(err_o),        64'(m_err));
    endtask

    task automatic idle(input logic rst);
        step(rst, 1'b0, '0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    typedef struct {
        logic          wv;
        logic [DW-1:0] wd;
        logic [BW-1:0] wb;
        logic [HW-1:0] wh;
        logic          av;
        logic [DW-1:0] a;
        logic [BW-1:0] ab;
        logic [AW-1:0] ps;
        logic [AW-1:0] e_psum;
        logic          e_vld;
        logic          e_err;
    } vec_t;

`ifdef PE_SAT_EN
    localparam logic [AW-1:0] SAT_EXP = 32'h7FFFFFFF;
`else
    localparam logic [AW-1:0] SAT_EXP = 32'h800000F0;
`endif

    initial begin
        vec_t tbl [8];
        logic          r_wv, r_av, r_rst;
        logic [DW-1:0] r_wd, r_a;
        logic [BW-1:0] r_wb, r_ab;
        logic [HW-1:0] r_wh;
        logic [AW-1:0] r_ps;

        //          wv  wd     wb  wh    av  a      ab  ps             e_psum          vld err
        tbl[0] = '{1'b0, 8'd0,  1'b0, 3'd0, 1'b0, 8'd0,   1'b0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'd5,  1'b1, 3'd0, 1'b0, 8'd0,   1'b0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'd0,  1'b0, 3'd0, 1'b1, 8'd3,   1'b1, 32'd10,       32'd25,       1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'hFE, 1'b0, 3'd0, 1'b0, 8'd0,   1'b0, 32'd7,        32'd7,        1'b0, 1'b0};
        tbl[4] = '{1'b1, 8'd7,  1'b0, 3'd0, 1'b1, 8'd127, 1'b0, 32'hFFFFFFFF, 32'hFFFFFF01, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 8'd0,  1'b0, 3'd0, 1'b1, 8'd127, 1'b0, 32'hFFFFFFFF, 32'd888,      1'b1, 1'b0};
        tbl[6] = '{1'b1, 8'd16, 1'b1, 3'd0, 1'b0, 8'd0,   1'b0, 32'd0,        32'd0,        1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'd0,  1'b0, 3'd0, 1'b1, 8'd16,  1'b1, 32'h7FFFFFF0, SAT_EXP,      1'b1, 1'b0};

        idle(1'b1);
        idle(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0, tbl[i].wv, tbl[i].wd, tbl[i].wb, tbl[i].wh,
                 tbl[i].av, tbl[i].a, tbl[i].ab, tbl[i].ps);
            check("tbl_psum", 64'(psum_o),       64'(tbl[i].e_psum));
            check("tbl_vld",  64'(psum_valid_o), 64'(tbl[i].e_vld));
            check("tbl_err",  64'(err_o),        64'(tbl[i].e_err));
        end

        // Forwarded beat leaves the local bank untouched; MAC on it then flags error stickily.
        idle(1'b1);
        step(1'b0, 1'b1, 8'd9, 1'b0, 3'd2, 1'b0, 8'd0, 1'b0, 32'd0);
        check("fwd_vld", 64'(w_valid_o), 64'd1);
        check("fwd_hop", 64'(w_hop_o),   64'd1);
        check("fwd_dat", 64'(w_data_o),  64'd9);
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 8'd4, 1'b0, 32'h1234);
        check("unl_psum", 64'(psum_o), 64'h1234);
        check("unl_err",  64'(err_o),  64'd1);
        for (int i = 0; i < 3; i++) idle(1'b0);
        check("err_sticky", 64'(err_o), 64'd1);
        idle(1'b1);
        check("err_clr", 64'(err_o), 64'd0);

        // Reset while a load and a forward are in flight wipes both.
        step(1'b0, 1'b1, 8'd9, 1'b1, 3'd0, 1'b0, 8'd0, 1'b0, 32'd0);
        step(1'b1, 1'b1, 8'd3, 1'b1, 3'd4, 1'b1, 8'd1, 1'b1, 32'd5);
        check("rst_wvld", 64'(w_valid_o), 64'd0);
        check("rst_psum", 64'(psum_o),    64'd0);
        step(1'b0, 1'b0, 8'd0, 1'b0, 3'd0, 1'b1, 8'd2, 1'b1, 32'd3);
        check("rst_bank_psum", 64'(psum_o), 64'd3);
        check("rst_bank_err",  64'(err_o),  64'd1);

        idle(1'b1);
        for (int n = 0; n < 3000; n++) begin
            r_rst = ($urandom_range(0, 63) == 0);
            r_wv  = 1'($urandom_range(0, 1));
            r_wd  = 8'($urandom);
            r_wb  = 1'($urandom_range(0, 1));
            r_wh  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            r_av  = 1'($urandom_range(0, 1));
            r_a   = 8'($urandom);
            r_ab  = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0:       r_ps = 32'($urandom);
                1:       r_ps = 32'h7FFFFF00 + 32'($urandom_range(0, 255));
                default: r_ps = 32'h80000000 + 32'($urandom_range(0, 255));
            endcase
            step(r_rst, r_wv, r_wd, r_wb, r_wh, r_av, r_a, r_ab, r_ps);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
